// File: rtl/rx_cic_pkg.sv
// Shared definitions for the receive CIC sequencing controller.
//   state_t      : controller FSM states
//   CH_I / CH_Q  : channel tags carried on the CIC output stream
//   DEF_MIN_RATE : default smallest decimation rate the CIC accepts
package rx_cic_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        RST    = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    localparam int DEF_MIN_RATE = 8;

endpackage

// File: rtl/rx_iq_pair.sv
// De-interleaves the CIC's channel-multiplexed output into I/Q pairs.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   enable                  : beats may be accepted (controller flowing)
//   discard                 : completed pairs are dropped instead of presented
//   flush                   : clears the I-pending flag
//   in_data/valid/channel/error, in_ready : CIC output beat handshake
//   out_i/out_q/out_valid, out_ready      : paired output stream
//   pair_done               : strobe, a Q beat completed a pair
//   pair_fault              : strobe, Q without I or I overwriting a pending I
//   beat_error              : strobe, accepted beat carried a nonzero error code
module rx_iq_pair
    import rx_cic_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              discard,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_channel,
    input  logic [1:0]        in_error,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              pair_done,
    output logic              pair_fault,
    output logic              beat_error
);

    logic              pend;
    logic [DATA_W-1:0] i_hold;
    logic              accept;

    // A beat is only taken when the output slot is free or draining this cycle,
    // so a completing Q beat can never overwrite a held pair.
    assign in_ready   = enable && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign pair_done  = accept && (in_channel == CH_Q) && pend;
    assign pair_fault = accept && (((in_channel == CH_Q) && !pend) ||
                                   ((in_channel == CH_I) && pend));
    assign beat_error = accept && (in_error != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            i_hold    <= '0;
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (flush) begin
                pend <= 1'b0;
            end else if (accept) begin
                if (in_channel == CH_I) begin
                    i_hold <= in_data;
                    pend   <= 1'b1;
                end else if (pend) begin
                    pend <= 1'b0;
                    if (!discard) begin
                        out_i     <= i_hold;
                        out_q     <= in_data;
                        out_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rx_cic_ctrl.sv
// Sequencing controller for the receive CIC decimator. Performs glitch-free
// rate changes (drain, hold CIC in reset, apply rate, discard settling pairs)
// and presents the CIC's interleaved output as I/Q pairs.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   cfg_rate/cfg_wr               : rate-change request
//   cfg_busy, cfg_reject          : change in progress / illegal-rate pulse
//   adc_valid/adc_ready           : upstream sample handshake
//   cic_in_valid/cic_in_ready     : CIC input handshake
//   cic_rate, cic_reset_n, cic_clken : CIC control
//   cic_out_*                     : CIC output stream (data, valid, channel, error, ready)
//   iq_i/iq_q/iq_valid/iq_ready   : paired output stream
//   sync_err, err_clr             : sticky pairing/CIC error flag and its clear
//   stat_drop, stat_sync          : statistics counters
// Build option RX_CIC_CTRL_STATS_EN: when defined, stat_drop counts discarded
// settling pairs and stat_sync counts pairing faults (saturating, cleared by
// err_clr); otherwise both read 0.
module rx_cic_ctrl
    import rx_cic_pkg::*;
#(
    parameter int RATE_W       = 11,
    parameter int DATA_W       = 32,
    parameter int MIN_RATE     = DEF_MIN_RATE,
    parameter int RST_CYC      = 4,
    parameter int SETTLE_PAIRS = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              cfg_wr,
    output logic              cfg_busy,
    output logic              cfg_reject,
    input  logic              adc_valid,
    output logic              adc_ready,
    output logic              cic_in_valid,
    input  logic              cic_in_ready,
    output logic [RATE_W-1:0] cic_rate,
    output logic              cic_reset_n,
    output logic              cic_clken,
    input  logic [DATA_W-1:0] cic_out_data,
    input  logic              cic_out_valid,
    input  logic              cic_out_channel,
    input  logic [1:0]        cic_out_error,
    output logic              cic_out_ready,
    output logic [DATA_W-1:0] iq_i,
    output logic [DATA_W-1:0] iq_q,
    output logic              iq_valid,
    input  logic              iq_ready,
    output logic              sync_err,
    input  logic              err_clr,
    output logic [15:0]       stat_drop,
    output logic [15:0]       stat_sync
);

    localparam int CNT_MAX = (RST_CYC > SETTLE_PAIRS) ? RST_CYC : SETTLE_PAIRS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [RATE_W-1:0] MIN_R = RATE_W'(MIN_RATE);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [RATE_W-1:0] new_rate;
    logic              latch, reject_n, flowing;
    logic              pair_done, pair_fault, beat_error;

    assign flowing      = (state == RUN) || (state == SETTLE);
    assign cfg_busy     = (state != RUN);
    assign cic_in_valid = flowing && adc_valid;
    assign adc_ready    = flowing && cic_in_ready;
    // Sequencing relies on reset and handshakes; the filter clock never gates.
    assign cic_clken    = 1'b1;

    rx_iq_pair #(.DATA_W(DATA_W)) u_pair (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (flowing),
        .discard    (state == SETTLE),
        .flush      (state == RST),
        .in_data    (cic_out_data),
        .in_valid   (cic_out_valid),
        .in_channel (cic_out_channel),
        .in_error   (cic_out_error),
        .in_ready   (cic_out_ready),
        .out_i      (iq_i),
        .out_q      (iq_q),
        .out_valid  (iq_valid),
        .out_ready  (iq_ready),
        .pair_done  (pair_done),
        .pair_fault (pair_fault),
        .beat_error (beat_error)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        latch    = 1'b0;
        reject_n = 1'b0;
        case (state)
            RUN: begin
                if (cfg_wr) begin
                    if (cfg_rate < MIN_R) begin
                        reject_n = 1'b1;
                    end else begin
                        state_n = DRAIN;
                        latch   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!iq_valid) begin
                    state_n = RST;
                    cnt_n   = CNT_W'(RST_CYC);
                end
            end
            RST: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n = (SETTLE_PAIRS == 0) ? RUN : SETTLE;
                    cnt_n   = CNT_W'(SETTLE_PAIRS);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (pair_done) begin
                    if (cnt <= CNT_W'(1))
                        state_n = RUN;
                    else
                        cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RST;
            cnt         <= CNT_W'(RST_CYC);
            new_rate    <= MIN_R;
            cic_rate    <= MIN_R;
            cic_reset_n <= 1'b0;
            cfg_reject  <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cfg_reject  <= reject_n;
            // Registered from next state so it is low exactly while in RST.
            cic_reset_n <= (state_n != RST);
            if (latch)
                new_rate <= cfg_rate;
            // Loaded only while already in RST, so the CIC sees a rate change
            // strictly while its reset is held low.
            if (state == RST)
                cic_rate <= new_rate;
            if (pair_fault || beat_error)
                sync_err <= 1'b1;
            else if (err_clr)
                sync_err <= 1'b0;
        end
    end

`ifdef RX_CIC_CTRL_STATS_EN
    logic        drop_inc;
    logic [15:0] drop_cnt, sync_cnt;

    assign drop_inc = pair_done && (state == SETTLE);

    // A clear coinciding with an event leaves that event counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            sync_cnt <= '0;
        end else begin
            if (err_clr)
                drop_cnt <= {15'd0, drop_inc};
            else if (drop_inc && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
            if (err_clr)
                sync_cnt <= {15'd0, pair_fault};
            else if (pair_fault && (sync_cnt != 16'hFFFF))
                sync_cnt <= sync_cnt + 16'd1;
        end
    end

    assign stat_drop = drop_cnt;
    assign stat_sync = sync_cnt;
`else
    assign stat_drop = 16'd0;
    assign stat_sync = 16'd0;
`endif

endmodule

// File: tb/tb_rx_cic_ctrl.sv
// Directed bench for rx_cic_ctrl: the bench plays the CIC output side and the
// downstream consumer. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_rx_cic_ctrl;

`ifdef RX_CIC_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] cfg_rate;
    logic        cfg_wr;
    logic        cfg_busy, cfg_reject;
    logic        adc_valid, adc_ready;
    logic        cic_in_valid, cic_in_ready;
    logic [10:0] cic_rate;
    logic        cic_reset_n, cic_clken;
    logic [31:0] cic_out_data;
    logic        cic_out_valid, cic_out_channel;
    logic [1:0]  cic_out_error;
    logic        cic_out_ready;
    logic [31:0] iq_i, iq_q;
    logic        iq_valid, iq_ready;
    logic        sync_err, err_clr;
    logic [15:0] stat_drop, stat_sync;

    int n_chk  = 0;
    int n_fail = 0;

    bit   rnd_en    = 1'b0;
    logic rnd_bit   = 1'b1;
    logic ready_req = 1'b1;
    logic [31:0] got_i[$];
    logic [31:0] got_q[$];

    assign iq_ready = rnd_en ? rnd_bit : ready_req;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (iq_valid && iq_ready) begin
            got_i.push_back(iq_i);
            got_q.push_back(iq_q);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    rx_cic_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_rate        (cfg_rate),
        .cfg_wr          (cfg_wr),
        .cfg_busy        (cfg_busy),
        .cfg_reject      (cfg_reject),
        .adc_valid       (adc_valid),
        .adc_ready       (adc_ready),
        .cic_in_valid    (cic_in_valid),
        .cic_in_ready    (cic_in_ready),
        .cic_rate        (cic_rate),
        .cic_reset_n     (cic_reset_n),
        .cic_clken       (cic_clken),
        .cic_out_data    (cic_out_data),
        .cic_out_valid   (cic_out_valid),
        .cic_out_channel (cic_out_channel),
        .cic_out_error   (cic_out_error),
        .cic_out_ready   (cic_out_ready),
        .iq_i            (iq_i),
        .iq_q            (iq_q),
        .iq_valid        (iq_valid),
        .iq_ready        (iq_ready),
        .sync_err        (sync_err),
        .err_clr         (err_clr),
        .stat_drop       (stat_drop),
        .stat_sync       (stat_sync)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic ch, input logic [31:0] d, input logic [1:0] e);
        bit ok = 1'b0;
        cic_out_valid   = 1'b1;
        cic_out_channel = ch;
        cic_out_data    = d;
        cic_out_error   = e;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = cic_out_ready;
            nxt();
        end
        cic_out_valid = 1'b0;
        cic_out_error = 2'b00;
        check("beat_accept", 32'(ok), 32'(1));
    endtask

    task automatic pair(input int k);
        beat(1'b0, 32'(k), 2'b00);
        beat(1'b1, 32'(-k), 2'b00);
    endtask

    // Waits for cic_reset_n to fall, then counts low falling-edge samples.
    task automatic rst_window(output int low_n, output logic [10:0] rate_in);
        int g = 0;
        low_n   = 0;
        rate_in = '0;
        @(negedge clk);
        while (cic_reset_n && g < 50) begin
            @(negedge clk);
            g++;
        end
        while (!cic_reset_n && low_n < 50) begin
            low_n++;
            rate_in = cic_rate;
            @(negedge clk);
        end
        nxt();
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int g = 0; g < 64 && !idle; g++) begin
            @(negedge clk);
            idle = !iq_valid;
            nxt();
        end
        check("iq_drain", 32'(idle), 32'(1));
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        nxt();
        err_clr = 1'b0;
    endtask

    initial begin
        int          n;
        logic [10:0] r;

        reset_n = 1'b0; cfg_rate = 11'd0; cfg_wr = 1'b0;
        adc_valid = 1'b1; cic_in_ready = 1'b1;
        cic_out_data = '0; cic_out_valid = 1'b0; cic_out_channel = 1'b0;
        cic_out_error = 2'b00; err_clr = 1'b0;
        repeat (3) nxt();

        // Reset state
        @(negedge clk);
        check("rst_cic_reset_n", 32'(cic_reset_n), 32'(0));
        check("rst_cic_rate", 32'(cic_rate), 32'(8));
        check("rst_busy", 32'(cfg_busy), 32'(1));
        check("rst_clken", 32'(cic_clken), 32'(1));
        check("rst_reject", 32'(cfg_reject), 32'(0));
        check("rst_iq_valid", 32'(iq_valid), 32'(0));
        check("rst_sync_err", 32'(sync_err), 32'(0));
        check("rst_adc_ready", 32'(adc_ready), 32'(0));
        check("rst_out_ready", 32'(cic_out_ready), 32'(0));
        check("rst_stat_drop", 32'(stat_drop), 32'(0));
        check("rst_stat_sync", 32'(stat_sync), 32'(0));
        nxt();

        // Startup: 4 reset cycles, then 5 discarded pairs
        reset_n = 1'b1;
        rst_window(n, r);
        check("boot_rst_cycles", 32'(n), 32'(4));
        check("boot_rate_in_rst", 32'(r), 32'(8));
        @(negedge clk);
        check("settle_busy", 32'(cfg_busy), 32'(1));
        check("settle_in_valid", 32'(cic_in_valid), 32'(1));
        check("settle_adc_ready", 32'(adc_ready), 32'(1));
        nxt();
        for (int k = 0; k < 4; k++) pair(100 + k);
        @(negedge clk);
        check("settle_busy_4", 32'(cfg_busy), 32'(1));
        nxt();
        pair(104);
        @(negedge clk);
        check("boot_busy_done", 32'(cfg_busy), 32'(0));
        check("boot_rate", 32'(cic_rate), 32'(8));
        check("boot_discarded", 32'(got_i.size()), 32'(0));
        check("boot_stat_drop", 32'(stat_drop), STATS ? 32'(5) : 32'(0));
        nxt();

        // RUN passthrough follows cic_in_ready
        cic_in_ready = 1'b0;
        @(negedge clk);
        check("run_adc_ready_lo", 32'(adc_ready), 32'(0));
        nxt();
        cic_in_ready = 1'b1;

        // Streaming under random backpressure
        rnd_en = 1'b1;
        for (int k = 1; k <= 8; k++) pair(k);
        rnd_en = 1'b0;
        wait_idle();
        check("stream_count", 32'(got_i.size()), 32'(8));
        for (int i = 0; i < 8 && i < got_i.size(); i++) begin
            check("stream_i", got_i[i], 32'(i + 1));
            check("stream_q", got_q[i], 32'(-(i + 1)));
        end
        got_i.delete(); got_q.delete();
        clr_pulse();
        @(negedge clk);
        check("clr_stat_drop", 32'(stat_drop), 32'(0));
        nxt();

        // Rate change to 64 with a pair stalled downstream
        ready_req = 1'b0;
        pair(7);
        cfg_rate = 11'd64; cfg_wr = 1'b1;
        nxt();
        cfg_wr = 1'b0;
        @(negedge clk);
        check("drain_busy", 32'(cfg_busy), 32'(1));
        check("drain_adc_ready", 32'(adc_ready), 32'(0));
        check("drain_in_valid", 32'(cic_in_valid), 32'(0));
        check("drain_out_ready", 32'(cic_out_ready), 32'(0));
        nxt();
        cfg_rate = 11'd4; cfg_wr = 1'b1;
        nxt();
        cfg_wr = 1'b0;
        repeat (2) nxt();
        @(negedge clk);
        check("drain_no_reject", 32'(cfg_reject), 32'(0));
        check("drain_held", 32'(cic_reset_n), 32'(1));
        check("drain_rate_old", 32'(cic_rate), 32'(8));
        check("drain_iq_valid", 32'(iq_valid), 32'(1));
        nxt();
        ready_req = 1'b1;
        rst_window(n, r);
        check("chg_rst_cycles", 32'(n), 32'(4));
        check("chg_rate_in_rst", 32'(r), 32'(64));
        for (int k = 0; k < 5; k++) pair(200 + k);
        @(negedge clk);
        check("chg_busy_done", 32'(cfg_busy), 32'(0));
        check("chg_rate", 32'(cic_rate), 32'(64));
        check("chg_pairs_out", 32'(got_i.size()), 32'(1));
        if (got_i.size() > 0) begin
            check("chg_held_i", got_i[0], 32'(7));
            check("chg_held_q", got_q[0], 32'(-7));
        end
        check("chg_stat_drop", 32'(stat_drop), STATS ? 32'(5) : 32'(0));
        nxt();
        got_i.delete(); got_q.delete();

        // Illegal rate
        cfg_rate = 11'd4; cfg_wr = 1'b1;
        nxt();
        cfg_wr = 1'b0;
        @(negedge clk);
        check("rej_pulse", 32'(cfg_reject), 32'(1));
        check("rej_busy", 32'(cfg_busy), 32'(0));
        nxt();
        @(negedge clk);
        check("rej_pulse_end", 32'(cfg_reject), 32'(0));
        check("rej_rate", 32'(cic_rate), 32'(64));
        check("rej_busy2", 32'(cfg_busy), 32'(0));
        nxt();

        // Channel sequence 0,1,1,0,1
        beat(1'b0, 32'(21), 2'b00);
        beat(1'b1, 32'(-21), 2'b00);
        beat(1'b1, 32'(99), 2'b00);
        beat(1'b0, 32'(22), 2'b00);
        beat(1'b1, 32'(-22), 2'b00);
        wait_idle();
        check("seq_pairs", 32'(got_i.size()), 32'(2));
        if (got_i.size() == 2) begin
            check("seq_i0", got_i[0], 32'(21));
            check("seq_q0", got_q[0], 32'(-21));
            check("seq_i1", got_i[1], 32'(22));
            check("seq_q1", got_q[1], 32'(-22));
        end
        @(negedge clk);
        check("seq_sync_err", 32'(sync_err), 32'(1));
        check("seq_stat_sync", 32'(stat_sync), STATS ? 32'(1) : 32'(0));
        nxt();
        clr_pulse();
        @(negedge clk);
        check("clr_sync_err", 32'(sync_err), 32'(0));
        check("clr_stat_sync", 32'(stat_sync), 32'(0));
        nxt();

        // Clear and a new fault in the same cycle: flag ends set
        err_clr = 1'b1;
        beat(1'b1, 32'(55), 2'b00);
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_race_sync_err", 32'(sync_err), 32'(1));
        nxt();
        clr_pulse();

        // Nonzero CIC error code sets the flag, not the pairing counter
        got_i.delete(); got_q.delete();
        beat(1'b0, 32'(31), 2'b10);
        beat(1'b1, 32'(-31), 2'b00);
        wait_idle();
        @(negedge clk);
        check("cicerr_sync_err", 32'(sync_err), 32'(1));
        check("cicerr_stat_sync", 32'(stat_sync), 32'(0));
        check("cicerr_pairs", 32'(got_i.size()), 32'(1));
        nxt();
        clr_pulse();
        got_i.delete(); got_q.delete();

        // reset_n during the RST phase of a change to 100
        cfg_rate = 11'd100; cfg_wr = 1'b1;
        nxt();
        cfg_wr = 1'b0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (!cic_reset_n) break;
        end
        nxt();
        @(negedge clk);
        check("mid_rate_loaded", 32'(cic_rate), 32'(100));
        nxt();
        reset_n = 1'b0;
        #1;
        check("mid_rate_reset", 32'(cic_rate), 32'(8));
        check("mid_busy", 32'(cfg_busy), 32'(1));
        repeat (2) nxt();
        reset_n = 1'b1;
        rst_window(n, r);
        check("mid_rst_cycles", 32'(n), 32'(4));
        check("mid_rate_in_rst", 32'(r), 32'(8));
        for (int k = 0; k < 5; k++) pair(300 + k);
        @(negedge clk);
        check("mid_busy_done", 32'(cfg_busy), 32'(0));
        check("mid_rate_final", 32'(cic_rate), 32'(8));
        check("mid_discarded", 32'(got_i.size()), 32'(0));
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_cic_ctrl.md
# rx_cic_ctrl

Sequencing controller for the receive CIC decimator. Owns the decimator's rate, reset and handshake ports, and performs glitch-free rate changes: input is blocked, the filter is reset, the new rate is applied and settling outputs are discarded. Also de-interleaves the filter's channel-multiplexed output into I/Q sample pairs for the downstream receive chain.

## Interface
- RATE_W, 11: decimation rate width.
- DATA_W, 32: CIC output sample width.
- MIN_RATE, 8: smallest accepted rate; below this a request is rejected.
- RST_CYC, 4: cycles `cic_reset_n` is held low during a rate change (≥1).
- SETTLE_PAIRS, 5: output pairs discarded after a rate change (≥0).
- Ports:
  - `clk` in 1: single clock.
  - `reset_n` in 1: asynchronous, active-low reset.
  - `cfg_rate` in RATE_W: requested rate.
  - `cfg_wr` in 1: one-cycle request strobe.
  - `cfg_busy` out 1: high while a change is in progress.
  - `cfg_reject` out 1: one-cycle pulse on an illegal request.
  - `adc_valid` in 1 / `adc_ready` out 1: upstream sample handshake.
  - `cic_in_valid` out 1 / `cic_in_ready` in 1: to the CIC input.
  - `cic_rate` out RATE_W: registered rate driven to the CIC.
  - `cic_reset_n` out 1: CIC reset, registered.
  - `cic_clken` out 1: CIC clock enable.
  - `cic_out_data` in DATA_W, `cic_out_valid` in 1, `cic_out_channel` in 1, `cic_out_error` in 2: from the CIC output.
  - `cic_out_ready` out 1: to the CIC output.
  - `iq_i`, `iq_q` out DATA_W each; `iq_valid` out 1; `iq_ready` in 1: paired output stream.
  - `sync_err` out 1: sticky; set on a pairing fault or a nonzero `cic_out_error`; cleared by `err_clr` in 1.
  - `stat_drop`, `stat_sync` out 16 each: statistics counters (see Configuration).

## Operation
- FSM states: RUN, DRAIN, RST, SETTLE.
- Reset values:
  - State is RST with counter = RST_CYC.
  - `cic_rate` = MIN_RATE; `cic_reset_n` = 0; `cic_clken` = 1.
  - `cfg_busy` = 1; `cfg_reject`, `iq_valid`, `sync_err` = 0; counters = 0; I-pending flag = 0.
- Request handling:
  - `cfg_wr` in RUN with `cfg_rate` ≥ MIN_RATE → DRAIN; the rate is latched.
  - `cfg_wr` with `cfg_rate` < MIN_RATE → `cfg_reject` pulse; state is unchanged.
  - `cfg_wr` while `cfg_busy` → ignored; no reject.
- DRAIN: `adc_ready` = 0 and `cic_in_valid` = 0. Leave for RST when `iq_valid` = 0 (no pair held downstream).
- RST:
  - `cic_reset_n` = 0 for RST_CYC cycles.
  - `cic_rate` loads the latched rate on entry.
  - I-pending flag is cleared.
  - Then → SETTLE.
- SETTLE: input flows; completed pairs are counted and discarded, not presented. After SETTLE_PAIRS pairs → RUN. If SETTLE_PAIRS = 0, go directly to RUN.
- Input passthrough (RUN, SETTLE): `cic_in_valid` = `adc_valid`, `adc_ready` = `cic_in_ready`. Both are 0 in DRAIN and RST.
- `cfg_busy` = (state ≠ RUN).
- Pairing:
  - A beat with channel 0 captures I and sets the pending flag.
  - A beat with channel 1 and the flag set forms a pair and clears the flag.
  - Channel 1 without the flag → beat dropped, `sync_err` set.
  - Channel 0 with the flag already set → old I overwritten, `sync_err` set.
- `cic_out_ready` = (RUN or SETTLE) and (`iq_valid` = 0 or `iq_ready` = 1).
- `iq_valid` holds with stable data until `iq_ready` is sampled high.
- `err_clr` and a new error in the same cycle → `sync_err` ends set.

## Timing
- Pair output latency: `iq_valid` asserts 1 cycle after the accepted Q beat.
- Full throughput: one pair every 2 accepted beats; no bubbles under continuous `iq_ready`.
- `cfg_busy` asserts in the cycle after `cfg_wr`.
- Minimum rate-change duration: 1 (DRAIN) + RST_CYC, plus settling time.
- `cic_rate` changes only while `cic_reset_n` = 0.
- `reset_n` mid-change: state returns to RST and `cic_rate` = MIN_RATE; a pending request is lost.

## Configuration
- `RX_CIC_CTRL_STATS_EN`:
  - Defined: `stat_drop` counts discarded settling pairs and `stat_sync` counts pairing faults. Both are 16-bit, saturate at 0xFFFF, and clear on `err_clr`.
  - Undefined: both outputs are tied to 0 and no counter logic is generated.

## Structure
- Shared package `rx_cic_pkg`:
  - FSM state enum {RUN, DRAIN, RST, SETTLE}.
  - Channel constants CH_I = 0, CH_Q = 1.
  - Default MIN_RATE.
- One sub-module, `rx_iq_pair`: pairing logic, pending flag and output register. It exposes error and pair-complete strobes to the FSM.

## Test plan
- Post-reset:
  - `cic_reset_n` low for 4 cycles, then SETTLE, with 5 pairs discarded.
  - Then RUN with `cic_rate` = 8; `cfg_busy` falls.
- Streaming at rate 8: inputs I = k and Q = −k → output pairs (k, −k) in order, with no loss under random `iq_ready` backpressure.
- `cfg_wr` with `cfg_rate` = 64:
  - DRAIN is held while `iq_valid` is stalled.
  - `cic_rate` = 64 while `cic_reset_n` = 0.
  - Exactly 5 pairs are discarded and `stat_drop` = 5.
- `cfg_rate` = 4 → single `cfg_reject` pulse; `cic_rate` unchanged; `cfg_busy` stays low.
- Channel sequence 0,1,1,0,1:
  - Third beat dropped; `sync_err` = 1 and `stat_sync` = 1; 2 pairs output.
  - `err_clr` clears `sync_err` and `stat_sync`.
- `reset_n` asserted during RST of a change to rate 100 → `cic_rate` = 8 and the full startup sequence repeats.
